mem_port_arbiter: RTL and testbench

// - Shares one single-port data/instruction RAM between the IF stage (read-only fetch) and the MEM stage (load/store).
// - Registers the winning request onto the RAM port and holds it until ram_ready. Returns a one-cycle done pulse with read data to the winner.
// - Generates stall_if / stall_mem so the pipeline freezes while a stage's access is pending.

---
 rtl/mem_port_arbiter.sv | 151 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port RAM between instruction fetch and load/store accesses.
// Optional IF starvation guard: define ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned TIMEOUT  = 16,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              mem_req,
  input  logic              mem_wen,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_done,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              err,
  output logic              ram_en,
  output logic              ram_wen,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              ram_ready,
  output logic              stall_if,
  output logic              stall_mem
);

  typedef enum logic [1:0] {IDLE, IF_ACC, MEM_ACC, DONE} state_t;

  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t        state, state_nxt;
  logic [TW-1:0] wait_cnt;
  logic          mem_sel, if_sel, force_if, timed_out;
  logic          take_mem, take_if, finish, abort;

  assign stall_if  = if_req  & ~if_done;
  assign stall_mem = mem_req & ~mem_done;

  assign mem_sel   = mem_req & ~mem_done;
  assign if_sel    = if_req  & ~if_done;
  assign timed_out = (TIMEOUT != 0) && (wait_cnt == TW'(TIMEOUT - 1));

`ifdef ARB_STARVE_GUARD_EN
  localparam int unsigned SW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

  logic [SW-1:0] starve_cnt;

  assign force_if = if_sel && (starve_cnt >= SW'(MAX_WAIT));

  // Counts back-to-back MEM wins that left a fetch waiting.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (take_if) begin
      starve_cnt <= '0;
    end else if (take_mem) begin
      starve_cnt <= if_req ? starve_cnt + 1'b1 : '0;
    end
  end
`else
  // Strict MEM priority; MAX_WAIT only matters with the guard compiled in.
  assign force_if = (MAX_WAIT == 0) && 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    take_mem  = 1'b0;
    take_if   = 1'b0;
    finish    = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: begin
        if (mem_sel && !force_if) begin
          take_mem  = 1'b1;
          state_nxt = MEM_ACC;
        end else if (if_sel) begin
          take_if   = 1'b1;
          state_nxt = IF_ACC;
        end
      end
      IF_ACC, MEM_ACC: begin
        if (ram_ready) begin
          finish    = 1'b1;
          state_nxt = DONE;
        end else if (timed_out) begin
          finish    = 1'b1;
          abort     = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      if_done   <= 1'b0;
      mem_done  <= 1'b0;
      err       <= 1'b0;
      if_rdata  <= '0;
      mem_rdata <= '0;
      ram_en    <= 1'b0;
      ram_wen   <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      wait_cnt  <= '0;
    end else begin
      if_done  <= 1'b0;
      mem_done <= 1'b0;
      err      <= 1'b0;
      if (take_mem) begin
        ram_en    <= 1'b1;
        ram_wen   <= mem_wen;
        ram_addr  <= mem_addr;
        ram_wdata <= mem_wdata;
        wait_cnt  <= '0;
      end else if (take_if) begin
        ram_en   <= 1'b1;
        ram_wen  <= 1'b0;
        ram_addr <= if_addr;
        wait_cnt <= '0;
      end else if (finish) begin
        ram_en  <= 1'b0;
        ram_wen <= 1'b0;
        err     <= abort;
        if (state == IF_ACC) begin
          if_done  <= 1'b1;
          if_rdata <= abort ? '0 : ram_rdata;
        end else begin
          mem_done <= 1'b1;
          // Stores leave the last load data in place.
          if (!ram_wen) mem_rdata <= abort ? '0 : ram_rdata;
        end
      end else if (state == IF_ACC || state == MEM_ACC) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus random traffic
// against a transaction-level model of the arbitration rules.
module tb_mem_port_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 16;
  localparam int unsigned MW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          if_req = 1'b0, mem_req = 1'b0, mem_wen = 1'b0, ram_ready = 1'b0;
  logic [AW-1:0] if_addr = '0, mem_addr = '0;
  logic [DW-1:0] mem_wdata = '0, ram_rdata = '0;
  logic          if_done, mem_done, err, ram_en, ram_wen, stall_if, stall_mem;
  logic [DW-1:0] if_rdata, mem_rdata, ram_wdata;
  logic [AW-1:0] ram_addr;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO), .MAX_WAIT(MW)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
    .mem_req(mem_req), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_done(mem_done), .mem_rdata(mem_rdata), .err(err),
    .ram_en(ram_en), .ram_wen(ram_wen), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .ram_ready(ram_ready),
    .stall_if(stall_if), .stall_mem(stall_mem)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Model: who owns the RAM (0 none, 1 IF, 2 MEM), ACC cycles spent, bubble pending.
  int            m_owner, m_acc, m_starve;
  bit            m_bubble, m_wen, m_mem_valid;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_if_rdata, m_mem_rdata;
  bit            e_if_done, e_mem_done, e_err;

  int            lat = 0;
  bit            rand_lat = 1'b0, rand_data = 1'b0;
  logic [DW-1:0] fix_data = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = 0; m_acc = 0; m_starve = 0; m_bubble = 0; m_wen = 0;
    m_mem_valid = 1; m_addr = '0; m_wdata = '0; m_if_rdata = '0; m_mem_rdata = '0;
    e_if_done = 0; e_mem_done = 0; e_err = 0;
  endtask

  // Advances the model across one rising edge using the inputs held at that edge.
  task automatic model_step();
    bit ab, force_if;
    e_if_done = 0; e_mem_done = 0; e_err = 0;
    if (m_owner != 0) begin
      m_acc++;
      if (ram_ready || (TO != 0 && m_acc == TO)) begin
        ab = !ram_ready;
        e_err = ab;
        if (m_owner == 1) begin
          e_if_done = 1;
          m_if_rdata = ab ? '0 : ram_rdata;
        end else begin
          e_mem_done = 1;
          if (!m_wen) begin
            m_mem_rdata = ab ? '0 : ram_rdata;
            m_mem_valid = 1;
          end else begin
            m_mem_valid = 0;
          end
        end
        m_owner = 0;
        m_bubble = 1;
      end
    end else if (m_bubble) begin
      m_bubble = 0;
    end else begin
      force_if = 0;
`ifdef ARB_STARVE_GUARD_EN
      force_if = if_req && (m_starve >= MW);
`endif
      m_acc = 0;
      if (mem_req && !force_if) begin
        m_owner = 2; m_wen = mem_wen; m_addr = mem_addr; m_wdata = mem_wdata;
        m_starve = if_req ? m_starve + 1 : 0;
      end else if (if_req) begin
        m_owner = 1; m_wen = 0; m_addr = if_addr;
        m_starve = 0;
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    if (!reset) model_reset();
    else        model_step();
    chk("ram_en", ram_en, m_owner != 0);
    if (m_owner != 0) begin
      chk("ram_wen", ram_wen, m_wen);
      chk("ram_addr", ram_addr, m_addr);
      if (m_wen) chk("ram_wdata", ram_wdata, m_wdata);
    end
    chk("if_done", if_done, e_if_done);
    chk("mem_done", mem_done, e_mem_done);
    chk("err", err, e_err);
    chk("if_rdata", if_rdata, m_if_rdata);
    if (m_mem_valid) chk("mem_rdata", mem_rdata, m_mem_rdata);
    chk("stall_if", stall_if, if_req & ~e_if_done);
    chk("stall_mem", stall_mem, mem_req & ~e_mem_done);
  endtask

  // One clock with compare, then requesters and RAM react for the next edge.
  task automatic tick();
    int r;
    cycle();
    if (if_req && e_if_done)   if_req = 1'b0;
    if (mem_req && e_mem_done) mem_req = 1'b0;
    if (rand_lat && m_owner == 0) begin
      r = $urandom_range(0, 15);
      lat = (r < 12) ? r % 4 : (r < 15 ? $urandom_range(5, 8) : 100);
    end
    ram_rdata = rand_data ? DW'($urandom) : fix_data;
    ram_ready = (m_owner != 0) && (m_acc >= lat);
  endtask

  int mem_before_if, if_cnt;
  bit got_if;

  initial begin
    model_reset();
    tick(); tick();
    chk("rst_ram_en", ram_en, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_done", {if_done, mem_done, err}, 0);
    reset = 1'b1;
    tick();

    // Single fetch, ready in the first ACC cycle.
    lat = 0; fix_data = 32'h2402000A;
    if_req = 1'b1; if_addr = 32'h100;
    tick();
    chk("fetch_ram_addr", ram_addr, 32'h100);
    chk("fetch_ram_en", ram_en, 1);
    tick();
    chk("fetch_done", if_done, 1);
    chk("fetch_rdata", if_rdata, 32'h2402000A);
    chk("fetch_err", err, 0);
    tick(); tick();

    // Store with two wait states.
    lat = 2;
    mem_req = 1'b1; mem_wen = 1'b1; mem_addr = 32'h40; mem_wdata = 32'hDEADBEEF;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("store_ram", {ram_en, ram_wen, ram_addr, ram_wdata}, {2'b11, 32'h40, 32'hDEADBEEF});
    end
    tick();
    chk("store_done", mem_done, 1);
    tick();
    chk("store_one_pulse", mem_done, 0);
    tick();

    // Contention: MEM load wins, IF follows the bubble.
    lat = 0; fix_data = 32'h12345678;
    if_req = 1'b1; if_addr = 32'h200;
    mem_req = 1'b1; mem_wen = 1'b0; mem_addr = 32'h80;
    tick();
    chk("cont_mem_first", ram_addr, 32'h80);
    chk("cont_stall_if", stall_if, 1);
    tick();
    chk("cont_mem_done", {mem_done, if_done}, 2'b10);
    tick();
    chk("cont_bubble", ram_en, 0);
    tick();
    chk("cont_if_addr", ram_addr, 32'h200);
    tick();
    chk("cont_if_done", if_done, 1);
    tick(); tick();

    // Load with five wait states.
    lat = 5; fix_data = 32'hCAFEF00D;
    mem_req = 1'b1; mem_wen = 1'b0; mem_addr = 32'h300;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("wait_hold", {ram_en, ram_addr, stall_mem, mem_done}, {1'b1, 32'h300, 2'b10});
    end
    tick();
    chk("wait_done", {mem_done, mem_rdata}, {1'b1, 32'hCAFEF00D});
    tick(); tick();

    // Timeout on a fetch.
    lat = 100;
    if_req = 1'b1; if_addr = 32'h400;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("to_pending", {ram_en, if_done}, 2'b10);
    end
    tick();
    chk("to_abort", {if_done, err, if_rdata}, {2'b11, 32'h0});
    tick();
    chk("to_err_clear", err, 0);
    tick();

    // Asynchronous reset in the middle of a MEM access.
    mem_req = 1'b1; mem_wen = 1'b1; mem_addr = 32'h500; mem_wdata = 32'h55AA55AA;
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst_mid_en", ram_en, 0);
    chk("rst_mid_regs", {mem_done, ram_addr, mem_rdata}, 0);
    mem_req = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick(); tick();

    // Continuous MEM traffic while a fetch waits.
    lat = 0; fix_data = 32'h0BADF00D;
    if_req = 1'b1; if_addr = 32'h600;
    mem_req = 1'b1; mem_wen = 1'b0; mem_addr = 32'h700;
    mem_before_if = 0; if_cnt = 0; got_if = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (if_done) begin got_if = 1; if_cnt++; end
      if (mem_done && !got_if) mem_before_if++;
      if (!mem_req && !got_if) mem_req = 1'b1;
    end
`ifdef ARB_STARVE_GUARD_EN
    chk("starve_mem_grants", mem_before_if, MW);
`else
    chk("strict_if_starved", if_cnt, 0);
    mem_req = 1'b0;
`endif
    for (int i = 0; i < 12; i++) tick();

    // Random traffic.
    rand_lat = 1'b1; rand_data = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (!if_req && $urandom_range(0, 2) == 0) begin
        if_req = 1'b1; if_addr = AW'($urandom) & ~AW'(3);
      end
      if (!mem_req && $urandom_range(0, 2) == 0) begin
        mem_req = 1'b1; mem_wen = 1'($urandom_range(0, 1));
        mem_addr = AW'($urandom) & ~AW'(3); mem_wdata = DW'($urandom);
      end
    end
    if_req = 1'b0; mem_req = 1'b0;
    for (int i = 0; i < 40; i++) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
